// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback register file: widths, WB control bit
// positions and the hardwired-zero register index.
package wb_regfile_pkg;

  localparam int DATA_W          = 32;
  localparam int ADDR_W          = 5;
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;
  localparam int ZERO_REG        = 0;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  // Split the raw 2-bit WB bus into named fields using the package bit positions.
  function automatic wb_ctrl_t decode_wb(input logic [1:0] wb);
    wb_ctrl_t c;
    c.reg_write  = wb[WB_REGWRITE_BIT];
    c.mem_to_reg = wb[WB_MEMTOREG_BIT];
    return c;
  endfunction

endpackage

// File: rtl/wb_sel_mux.sv
// Writeback data select: load data when MemtoReg is set, ALU result otherwise.
module wb_sel_mux #(
  parameter int DATA_W = wb_regfile_pkg::DATA_W
) (
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] alu_in,
  output logic [DATA_W-1:0] wb_data
);

  // Explicit if/else so an unknown on the unselected input never reaches wb_data.
  always_comb begin
    wb_data = alu_in;
    if (mem_to_reg == 1'b1) begin
      wb_data = mem_in;
    end else begin
      wb_data = alu_in;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Register file with writeback commit, read-during-write bypass on both read
// ports, a registered forwarding copy of the last commit and a commit counter.
module wb_regfile #(
  parameter int DATA_W = wb_regfile_pkg::DATA_W,
  parameter int ADDR_W = wb_regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        WB_in,
  input  logic [ADDR_W-1:0] RD_in,
  input  logic [DATA_W-1:0] MEM_in,
  input  logic [DATA_W-1:0] ALU_in,
  input  logic [ADDR_W-1:0] RS_addr,
  input  logic [ADDR_W-1:0] RT_addr,
  output logic [DATA_W-1:0] RS_data,
  output logic [DATA_W-1:0] RT_data,
  output logic              FWD_valid,
  output logic [ADDR_W-1:0] FWD_rd,
  output logic [DATA_W-1:0] FWD_data,
  output logic [15:0]       WR_count
);

  import wb_regfile_pkg::*;

  localparam int                NREGS    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  wb_ctrl_t          wb_ctrl;
  logic [DATA_W-1:0] wb_data;
  logic              commit;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              fwd_valid_q, fwd_valid_d;
  logic [ADDR_W-1:0] fwd_rd_q, fwd_rd_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic [15:0]       wr_count_q, wr_count_d;
  logic [DATA_W-1:0] rs_data, rt_data;

  assign wb_ctrl = decode_wb(WB_in);

  wb_sel_mux #(.DATA_W(DATA_W)) u_wb_sel_mux (
    .mem_to_reg (wb_ctrl.mem_to_reg),
    .mem_in     (MEM_in),
    .alu_in     (ALU_in),
    .wb_data    (wb_data)
  );

  // Gating on rst_n keeps a write, and its bypass, from taking effect during reset.
  always_comb begin
    commit = 1'b0;
    if (rst_n && wb_ctrl.reg_write && (RD_in != ZERO_IDX)) begin
      commit = 1'b1;
    end else begin
      commit = 1'b0;
    end
  end

  always_comb begin
    rs_data = regs_q[RS_addr];
    if (RS_addr == ZERO_IDX) begin
      rs_data = '0;
    end else if (commit && (RS_addr == RD_in)) begin
      rs_data = wb_data;
    end else begin
      rs_data = regs_q[RS_addr];
    end
  end

  always_comb begin
    rt_data = regs_q[RT_addr];
    if (RT_addr == ZERO_IDX) begin
      rt_data = '0;
    end else if (commit && (RT_addr == RD_in)) begin
      rt_data = wb_data;
    end else begin
      rt_data = regs_q[RT_addr];
    end
  end

  // Next-state for storage, forwarding copy and counter; rd/data hold when idle.
  always_comb begin
    regs_d      = regs_q;
    fwd_valid_d = 1'b0;
    fwd_rd_d    = fwd_rd_q;
    fwd_data_d  = fwd_data_q;
    wr_count_d  = wr_count_q;
    if (commit) begin
      regs_d[RD_in] = wb_data;
      fwd_valid_d   = 1'b1;
      fwd_rd_d      = RD_in;
      fwd_data_d    = wb_data;
      wr_count_d    = wr_count_q + 16'd1;
    end else begin
      fwd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      fwd_valid_q <= 1'b0;
      fwd_rd_q    <= '0;
      fwd_data_q  <= '0;
      wr_count_q  <= 16'd0;
    end else begin
      regs_q      <= regs_d;
      fwd_valid_q <= fwd_valid_d;
      fwd_rd_q    <= fwd_rd_d;
      fwd_data_q  <= fwd_data_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign RS_data   = rs_data;
  assign RT_data   = rt_data;
  assign FWD_valid = fwd_valid_q;
  assign FWD_rd    = fwd_rd_q;
  assign FWD_data  = fwd_data_q;
  assign WR_count  = wr_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed plus randomized bench for wb_regfile against an array-based model
// of the register file, forwarding copy and commit counter.
`timescale 1ns/1ps
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic [1:0]  wb_in;
  logic [4:0]  rd_in;
  logic [31:0] mem_in;
  logic [31:0] alu_in;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [15:0] wr_count;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_regs [32];
  logic        m_fv;
  logic [4:0]  m_frd;
  logic [31:0] m_fdata;
  logic [15:0] m_cnt;

  wb_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .WB_in     (wb_in),
    .RD_in     (rd_in),
    .MEM_in    (mem_in),
    .ALU_in    (alu_in),
    .RS_addr   (rs_addr),
    .RT_addr   (rt_addr),
    .RS_data   (rs_data),
    .RT_data   (rt_data),
    .FWD_valid (fwd_valid),
    .FWD_rd    (fwd_rd),
    .FWD_data  (fwd_data),
    .WR_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit, n_vec=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic com,
                                             input logic [4:0] rd, input logic [31:0] wb);
    if (a == 5'd0)              return 32'd0;
    else if (com && (a == rd))  return wb;
    else                        return m_regs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_fv = 1'b0; m_frd = 5'd0; m_fdata = 32'd0; m_cnt = 16'd0;
  endtask

  task automatic model_edge(input logic com, input logic [4:0] rd, input logic [31:0] wb);
    if (!rst_n) begin
      model_clear();
    end else if (com) begin
      m_regs[rd] = wb;
      m_cnt      = m_cnt + 16'd1;
      m_fv       = 1'b1;
      m_frd      = rd;
      m_fdata    = wb;
    end else begin
      m_fv = 1'b0;
    end
  endtask

  // One cycle: drive after negedge, check read ports, clock, check registered outputs.
  task automatic apply(input logic we, input logic m2r, input logic [4:0] rd,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] rs, input logic [4:0] rt, input string tag);
    logic [31:0] wb;
    logic        com;
    @(negedge clk);
    wb_in = {we, m2r}; rd_in = rd; mem_in = mem; alu_in = alu;
    rs_addr = rs; rt_addr = rt;
    wb  = m2r ? mem : alu;
    com = we && (rd != 5'd0) && rst_n;
    #1;
    check({tag, "_rs"}, rs_data, model_read(rs, com, rd, wb));
    check({tag, "_rt"}, rt_data, model_read(rt, com, rd, wb));
    @(posedge clk);
    model_edge(com, rd, wb);
    #1;
    check({tag, "_fv"},  {31'd0, fwd_valid}, {31'd0, m_fv});
    check({tag, "_frd"}, {27'd0, fwd_rd},    {27'd0, m_frd});
    check({tag, "_fd"},  fwd_data,           m_fdata);
    check({tag, "_cnt"}, {16'd0, wr_count},  {16'd0, m_cnt});
  endtask

  initial begin
    logic        we, m2r;
    logic [4:0]  rd, rs, rt;
    logic [31:0] wdat;

    rst_n = 1'b0; wb_in = 2'b00; rd_in = 5'd0; mem_in = 32'd0; alu_in = 32'd0;
    rs_addr = 5'd0; rt_addr = 5'd0;
    repeat (3) @(posedge clk);
    model_clear();
    #1;
    check("rst_fv",  {31'd0, fwd_valid}, 32'd0);
    check("rst_frd", {27'd0, fwd_rd},    32'd0);
    check("rst_fd",  fwd_data,           32'd0);
    check("rst_cnt", {16'd0, wr_count},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      apply(1'b0, 1'b0, 5'(i), 32'd0, 32'd0, 5'(i), 5'(31 - i), "rd_all");
    end

    apply(1'b1, 1'b0, 5'd5, 32'h0000DEAD, 32'h00001234, 5'd0, 5'd0, "wr5");
    check("wr5_fv",  {31'd0, fwd_valid}, 32'd1);
    check("wr5_frd", {27'd0, fwd_rd},    32'd5);
    check("wr5_fd",  fwd_data,           32'h00001234);
    check("wr5_cnt", {16'd0, wr_count},  32'd1);
    apply(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd0, "rd5");
    check("rd5_hold_frd", {27'd0, fwd_rd}, 32'd5);

    apply(1'b1, 1'b1, 5'd7, 32'hCAFEF00D, 32'h11111111, 5'd7, 5'd7, "byp7");
    apply(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h22222222, 5'd0, 5'd0, "wr0");
    check("wr0_fv",  {31'd0, fwd_valid}, 32'd0);
    check("wr0_cnt", {16'd0, wr_count},  32'd2);

    apply(1'b1, 1'b0, 5'd12, 'x, 32'h0BADC0DE, 5'd12, 5'd5, "xmem");
    apply(1'b1, 1'b1, 5'd13, 32'h600DF00D, 'x, 5'd13, 5'd12, "xalu");

    for (int i = 0; i < 300; i++) begin
      we  = ($urandom_range(0, 3) != 0);
      m2r = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 31));
      rs  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rt  = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      apply(we, m2r, rd, $urandom, $urandom, rs, rt, "rand");
    end

    while (m_cnt != 16'hFFFF) begin
      @(negedge clk);
      wdat = $urandom;
      wb_in = 2'b10; rd_in = 5'd9; alu_in = wdat; mem_in = 32'd0;
      @(posedge clk);
      model_edge(1'b1, 5'd9, wdat);
    end
    #1;
    check("pre_wrap_cnt", {16'd0, wr_count}, 32'h0000FFFF);
    apply(1'b1, 1'b0, 5'd9, 32'd0, 32'h00000042, 5'd9, 5'd0, "wrap");
    check("wrap_cnt", {16'd0, wr_count}, 32'd0);

    apply(1'b1, 1'b0, 5'd3, 32'd0, 32'h000000AA, 5'd0, 5'd0, "wr3");
    rst_n = 1'b0;
    apply(1'b1, 1'b0, 5'd3, 32'd0, 32'h00000055, 5'd3, 5'd3, "rst_wr3");
    rst_n = 1'b1;
    apply(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd3, 5'd9, "post_rst");
    check("post_rst_fv", {31'd0, fwd_valid}, 32'd0);
    check("post_rst_r3", rs_data, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, default 32: register and data width.
REQ-002 Parameter ADDR_W, default 5: register index width, giving 2**ADDR_W registers.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1: synchronous active-low reset.
REQ-006 WB_in  input  2: writeback control; bit1 = RegWrite, bit0 = MemtoReg (1 selects MEM_in, 0 selects ALU_in).
REQ-007 RD_in  input  ADDR_W: destination register index.
REQ-008 MEM_in  input  DATA_W: load data from the memory stage.
REQ-009 ALU_in  input  DATA_W: ALU result.
REQ-010 RS_addr, RT_addr  input  ADDR_W each: read-port indices.
REQ-011 RS_data, RT_data  output  DATA_W each: read-port data.
REQ-012 FWD_valid  output  1: previous cycle committed a write.
REQ-013 FWD_rd  output  ADDR_W: index of the last committed write.
REQ-014 FWD_data  output  DATA_W: data of the last committed write.
REQ-015 WR_count  output  16: number of committed writes since reset.

Function
REQ-016 wb_data SHALL be MEM_in when WB_in[0]=1, else ALU_in.
REQ-017 A write SHALL commit when WB_in[1]=1 and RD_in!=0: reg[RD_in] <= wb_data at the rising edge.
REQ-018 A write with RD_in=0, or with WB_in[1]=0, SHALL change no register and SHALL NOT count as committed.
REQ-019 reg[0] SHALL always read 0.
REQ-020 Read ports SHALL be combinational, with zero-cycle latency from address to data.
REQ-021 Read-during-write bypass: when a write is committing this cycle and RS_addr (or RT_addr) equals RD_in and is nonzero, the port SHALL return wb_data, not the stored value.
REQ-022 Both read ports SHALL bypass independently; RS_addr=RT_addr=RD_in SHALL return wb_data on both ports.
REQ-023 FWD_valid/FWD_rd/FWD_data SHALL be registered copies of commit/RD_in/wb_data, with 1-cycle latency.
REQ-024 FWD_rd and FWD_data SHALL hold their values when no write commits; only FWD_valid SHALL drop to 0.
REQ-025 WR_count SHALL increment by 1 per committed write and wrap 0xFFFF->0x0000.
REQ-026 X/undriven MEM_in SHALL NOT affect state when MemtoReg=0; ALU_in likewise when MemtoReg=1.

Reset
REQ-027 While rst_n=0 at a rising edge, all registers SHALL clear to 0, FWD_valid=0, FWD_rd=0, FWD_data=0, and WR_count=0.
REQ-028 A write presented in the same cycle that rst_n=0 SHALL be discarded; reset wins.
REQ-029 Read ports SHALL return 0 for any address in the cycle after reset; bypass SHALL stay disabled while rst_n=0.

Structure
REQ-030 The shared package SHALL hold WB_REGWRITE_BIT=1, WB_MEMTOREG_BIT=0, DATA_W, ADDR_W and the zero-register index.
REQ-031 One sub-module, wb_sel_mux, SHALL implement REQ-016; storage, bypass and forwarding registers SHALL live in wb_regfile.

Verification
REQ-032 Reset, then read all 32 indices -> every RS_data and RT_data = 0, and WR_count=0.
REQ-033 WB_in=2'b10, RD_in=5, ALU_in=0x1234, MEM_in=0xDEAD; next cycle RS_addr=5 -> RS_data=0x1234, FWD_valid=1, FWD_rd=5, FWD_data=0x1234, WR_count=1.
REQ-034 WB_in=2'b11, RD_in=7, MEM_in=0xCAFEF00D with RS_addr=RT_addr=7 in the same cycle -> both ports = 0xCAFEF00D before the edge.
REQ-035 WB_in=2'b11, RD_in=0, MEM_in=0xFFFFFFFF -> reg0 reads 0, FWD_valid=0, WR_count unchanged.
REQ-036 WR_count preloaded to 0xFFFF by 65535 writes, then one more write -> WR_count=0x0000.
REQ-037 rst_n=0 coincident with WB_in=2'b10, RD_in=3, ALU_in=0x55 -> reg3 reads 0 afterwards, FWD_valid=0.
